uart_rx_fsm: RTL and testbench

//  Frame-control FSM of the UART receiver. Sits beside edge_bit_counter in uart_rx_top.

---
 rtl/uart_rx_fsm_pkg.sv | 29 ++
 rtl/uart_rx_fsm_if.sv | 48 ++++
 rtl/uart_rx_fsm.sv | 125 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receive frame-control FSM:
// state encoding, default widths, the MID sampling offset and a
// state decoder that folds unused encodings back onto IDLE.
package uart_rx_fsm_pkg;

    localparam int PRESCALE_WIDTH_DEF = 6;
    localparam int N_BITS_DEF         = 4;
    localparam int DATA_WIDTH_DEF     = 8;

    // The sampler result is stable this many ticks past mid-bit.
    localparam int MID_OFFSET = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Any encoding outside IDLE..STOP behaves exactly like IDLE.
    function automatic rx_state_t decode_state(input rx_state_t raw);
        case (raw)
            START, DATA, PARITY, STOP: return raw;
            default:                   return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the frame FSM and its neighbours
// (edge/bit counter, sampler, deserializer and the three checkers).
// master = the FSM, slave = everything around it.
interface uart_rx_fsm_if
    import uart_rx_fsm_pkg::*;
#(
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int N_BITS         = N_BITS_DEF
);

    // Line and configuration
    logic                      rx_in;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;

    // From the edge/bit counter and the checkers
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [N_BITS-1:0]         bit_cnt;
    logic                      strt_glitch;
    logic                      par_err;
    logic                      stp_err;

    // FSM results
    logic                      cnt_enable;
    logic                      dat_samp_en;
    logic                      strt_chk_en;
    logic                      deser_en;
    logic                      par_chk_en;
    logic                      stp_chk_en;
    logic                      data_valid;
    logic                      frame_err;
    logic                      busy;

    modport master (
        input  rx_in, prescale, par_en, edge_cnt, bit_cnt,
               strt_glitch, par_err, stp_err,
        output cnt_enable, dat_samp_en, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, busy
    );

    modport slave (
        output rx_in, prescale, par_en, edge_cnt, bit_cnt,
               strt_glitch, par_err, stp_err,
        input  cnt_enable, dat_samp_en, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, busy
    );

endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver frame-control FSM. Walks START/DATA/PARITY/STOP using
// the sibling edge/bit counter, fires one-cycle strobes at mid-bit to
// the sampler-side blocks and reports each frame with a registered
// one-cycle data_valid or frame_err in the first IDLE cycle.
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int N_BITS         = N_BITS_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fsm_if.master bus
);

    localparam int N_STROBES = 4;
    localparam rx_state_t STROBE_STATE [N_STROBES] = '{START, DATA, PARITY, STOP};

    rx_state_t                 state_reg;
    rx_state_t                 state_cur;
    logic                      par_en_q;
    logic                      data_valid_reg;
    logic                      frame_err_reg;

    logic [PRESCALE_WIDTH-1:0] end_tick;
    logic [PRESCALE_WIDTH-1:0] mid_tick;
    logic                      at_end;
    logic                      at_mid;
    logic                      last_data_bit;
    logic                      bit_overrun;
    logic [N_STROBES-1:0]      strobe_vec;

    // Bit-period timing points derived from the oversampling ratio.
    assign end_tick      = bus.prescale - PRESCALE_WIDTH'(1);
    assign mid_tick      = (bus.prescale >> 1) + PRESCALE_WIDTH'(MID_OFFSET);
    assign at_end        = (bus.edge_cnt == end_tick);
    assign at_mid        = (bus.edge_cnt == mid_tick);
    assign last_data_bit = (bus.bit_cnt == N_BITS'(DATA_WIDTH));
    assign bit_overrun   = (bus.bit_cnt >  N_BITS'(DATA_WIDTH));

    // Fold unused state encodings onto IDLE before anything looks at them.
    always_comb begin
        state_cur = decode_state(state_reg);
    end

    // Frame sequencing plus the registered end-of-frame result pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            par_en_q       <= 1'b0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (state_cur)
                IDLE: begin
                    if (!bus.rx_in) begin
                        state_reg <= START;
                        par_en_q  <= bus.par_en;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                START: begin
                    if (at_end) begin
                        state_reg <= bus.strt_glitch ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (at_end) begin
                        if (bit_overrun) begin
                            // Counter out of step with the frame: abandon it.
                            state_reg     <= IDLE;
                            frame_err_reg <= 1'b1;
                        end else if (last_data_bit) begin
                            state_reg <= par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (at_end) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    if (at_end) begin
                        state_reg <= IDLE;
                        if (bus.par_err || bus.stp_err) begin
                            frame_err_reg <= 1'b1;
                        end else begin
                            data_valid_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // One mid-bit strobe per bit-carrying state.
    genvar gi;
    generate
        for (gi = 0; gi < N_STROBES; gi++) begin : g_strobe
            assign strobe_vec[gi] = (state_cur == STROBE_STATE[gi]) && at_mid;
        end
    endgenerate

    assign bus.strt_chk_en = strobe_vec[0];
    assign bus.deser_en    = strobe_vec[1];
    assign bus.par_chk_en  = strobe_vec[2];
    assign bus.stp_chk_en  = strobe_vec[3];

    // Counter, sampler and busy all track "inside a frame".
    assign bus.busy        = (state_cur != IDLE);
    assign bus.cnt_enable  = bus.busy;
    assign bus.dat_samp_en = bus.busy;

    assign bus.data_valid  = data_valid_reg;
    assign bus.frame_err   = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a behavioural edge/bit counter sits beside the
// FSM, a serial driver produces frames and a negedge monitor timestamps
// every strobe and result pulse. Expectations come from frame arithmetic.
module tb_uart_rx_fsm;

    localparam int PW = 6;
    localparam int NB = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;

    uart_rx_fsm_if #(.PRESCALE_WIDTH(PW), .N_BITS(NB)) bus ();

    uart_rx_fsm #(.PRESCALE_WIDTH(PW), .N_BITS(NB), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int skip_at = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge/bit counter: ticks while enabled, clears when disabled.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (!bus.cnt_enable) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (bus.edge_cnt == bus.prescale - 6'd1) begin
            bus.edge_cnt <= '0;
            if (int'(bus.bit_cnt) == skip_at) bus.bit_cnt <= bus.bit_cnt + 4'd2;
            else                              bus.bit_cnt <= bus.bit_cnt + 4'd1;
        end else begin
            bus.edge_cnt <= bus.edge_cnt + 6'd1;
        end
    end

    logic [8:0] outs_w;
    assign outs_w = {bus.cnt_enable, bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
                     bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.busy};

    // Monitor: event timestamps and strobe placement.
    int   start_q[$];
    int   end_q[$];
    int   dv_q[$];
    int   fe_q[$];
    int   deser_cnt = 0, par_chk_cnt = 0, strt_chk_cnt = 0, stp_chk_cnt = 0;
    int   strobe_bad = 0, both_cnt = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        int mid;
        mid = int'(bus.prescale >> 1) + 2;
        if (bus.busy && !busy_prev) start_q.push_back(cyc);
        if (!bus.busy && busy_prev) end_q.push_back(cyc);
        busy_prev <= bus.busy;
        if (bus.data_valid) dv_q.push_back(cyc);
        if (bus.frame_err)  fe_q.push_back(cyc);
        if (bus.data_valid && bus.frame_err) both_cnt <= both_cnt + 1;
        if (bus.deser_en)    deser_cnt    <= deser_cnt + 1;
        if (bus.par_chk_en)  par_chk_cnt  <= par_chk_cnt + 1;
        if (bus.strt_chk_en) strt_chk_cnt <= strt_chk_cnt + 1;
        if (bus.stp_chk_en)  stp_chk_cnt  <= stp_chk_cnt + 1;
        if ((bus.deser_en || bus.par_chk_en || bus.strt_chk_en || bus.stp_chk_en) &&
            int'(bus.edge_cnt) != mid)
            strobe_bad <= strobe_bad + 1;
        if (bus.cnt_enable !== bus.busy || bus.dat_samp_en !== bus.busy)
            strobe_bad <= strobe_bad + 1;
    end

    // Reference: busy length of a frame measured from START entry.
    function automatic int frame_cycles(input int p, input bit pen, input bit glitch);
        if (glitch) return p;
        return p * (1 + DW + (pen ? 1 : 0) + 1);
    endfunction

    task automatic configure(input int p, input bit pen, input bit glitch,
                             input bit perr, input bit serr);
        bus.prescale    = 6'(p);
        bus.par_en      = pen;
        bus.strt_glitch = glitch;
        bus.par_err     = perr;
        bus.stp_err     = serr;
    endtask

    // Serial line: start, DW data bits LSB first, optional parity, stop.
    task automatic drive_frame(input int p, input bit pen, input logic [7:0] data);
        logic [10:0] bits;
        int          n;
        bits = {1'b1, ^data, data, 1'b0};
        n    = pen ? 11 : 10;
        for (int i = 0; i < n; i++) begin
            bus.rx_in = (i == n - 1) ? 1'b1 : bits[i];
            repeat (p) @(posedge clk);
            #1;
        end
        bus.rx_in = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        bus.rx_in  = 1'b1;
        configure(8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs_w !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", outs_w, 9'b0);
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_frame;
        int sb, db, fb, deb, pb, lat;
        bit ok;
        sb = start_q.size(); db = dv_q.size(); fb = fe_q.size();
        deb = deser_cnt; pb = par_chk_cnt;
        configure(8, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_frame(8, 1'b0, 8'hA5);
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clean_timeout: busy stuck"); end
        lat = (dv_q.size() > db && start_q.size() > sb) ? dv_q[db] - start_q[sb] : -1;
        checks++;
        if (lat != frame_cycles(8, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL clean_latency: got %0d want %0d", lat, frame_cycles(8, 1'b0, 1'b0));
        end
        checks++;
        if (dv_q.size() - db != 1 || fe_q.size() - fb != 0) begin
            errors++;
            $display("FAIL clean_pulses: dv=%0d fe=%0d want dv=1 fe=0", dv_q.size() - db, fe_q.size() - fb);
        end
        checks++;
        if (deser_cnt - deb != DW || par_chk_cnt - pb != 0) begin
            errors++;
            $display("FAIL clean_strobes: deser=%0d par=%0d want %0d/0", deser_cnt - deb, par_chk_cnt - pb, DW);
        end
        checks++;
        if (strobe_bad != 0) begin
            errors++;
            $display("FAIL clean_strobe_place: got %0d bad want 0", strobe_bad);
        end
        $display("test_clean_frame 0xA5 latency=%0d", lat);
    endtask

    task automatic test_parity_error;
        int sb, db, fb, pb, lat;
        bit ok;
        sb = start_q.size(); db = dv_q.size(); fb = fe_q.size(); pb = par_chk_cnt;
        configure(8, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_frame(8, 1'b1, 8'h3C);
        wait_idle(100, ok);
        lat = (fe_q.size() > fb && start_q.size() > sb) ? fe_q[fb] - start_q[sb] : -1;
        checks++;
        if (!ok || lat != frame_cycles(8, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL parerr_latency: got %0d want %0d", lat, frame_cycles(8, 1'b1, 1'b0));
        end
        checks++;
        if (fe_q.size() - fb != 1 || dv_q.size() - db != 0) begin
            errors++;
            $display("FAIL parerr_pulses: fe=%0d dv=%0d want fe=1 dv=0", fe_q.size() - fb, dv_q.size() - db);
        end
        checks++;
        if (par_chk_cnt - pb != 1) begin
            errors++;
            $display("FAIL parerr_parchk: got %0d want 1", par_chk_cnt - pb);
        end
        configure(8, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("test_parity_error 0x3C latency=%0d", lat);
    endtask

    task automatic test_start_glitch;
        int sb, eb, db, fb, deb, stb, dur;
        bit ok;
        sb = start_q.size(); eb = end_q.size(); db = dv_q.size(); fb = fe_q.size();
        deb = deser_cnt; stb = strt_chk_cnt;
        configure(8, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.rx_in = 1'b1;
        wait_idle(50, ok);
        dur = (end_q.size() > eb && start_q.size() > sb) ? end_q[eb] - start_q[sb] : -1;
        checks++;
        if (!ok || dur != frame_cycles(8, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL glitch_duration: got %0d want %0d", dur, frame_cycles(8, 1'b0, 1'b1));
        end
        checks++;
        if (deser_cnt - deb != 0 || dv_q.size() - db != 0 || fe_q.size() - fb != 0) begin
            errors++;
            $display("FAIL glitch_no_output: deser=%0d dv=%0d fe=%0d want 0", deser_cnt - deb,
                     dv_q.size() - db, fe_q.size() - fb);
        end
        checks++;
        if (strt_chk_cnt - stb != 1 || bus.cnt_enable !== 1'b0) begin
            errors++;
            $display("FAIL glitch_strt_chk: strt=%0d cnt_enable=%b want 1/0", strt_chk_cnt - stb, bus.cnt_enable);
        end
        configure(8, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("test_start_glitch duration=%0d", dur);
    endtask

    task automatic test_back_to_back;
        int sb, db, lat0, lat1, gap;
        bit ok;
        sb = start_q.size(); db = dv_q.size();
        configure(16, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_frame(16, 1'b0, 8'h5A);
        drive_frame(16, 1'b0, 8'hC3);
        wait_idle(400, ok);
        checks++;
        if (!ok || start_q.size() - sb != 2 || dv_q.size() - db != 2) begin
            errors++;
            $display("FAIL b2b_counts: starts=%0d dv=%0d want 2/2", start_q.size() - sb, dv_q.size() - db);
        end
        lat0 = -1; lat1 = -1; gap = -1;
        if (start_q.size() - sb >= 2 && dv_q.size() - db >= 2) begin
            lat0 = dv_q[db] - start_q[sb];
            lat1 = dv_q[db + 1] - start_q[sb + 1];
            gap  = start_q[sb + 1] - dv_q[db];
        end
        checks++;
        if (lat0 != frame_cycles(16, 1'b0, 1'b0) || lat1 != frame_cycles(16, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL b2b_latency: got %0d/%0d want %0d", lat0, lat1, frame_cycles(16, 1'b0, 1'b0));
        end
        checks++;
        if (gap != 1) begin
            errors++;
            $display("FAIL b2b_restart_gap: got %0d want 1", gap);
        end
        $display("test_back_to_back lat=%0d/%0d gap=%0d", lat0, lat1, gap);
    endtask

    task automatic test_reset_mid_frame;
        int sb, db, fb;
        bit found;
        configure(8, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rx_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy && bus.bit_cnt == 4'd4 && bus.edge_cnt == 6'd3) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midreset_reach: bit_cnt=4 never seen"); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs_w !== 9'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b want %b", outs_w, 9'b0);
        end
        bus.rx_in = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb = start_q.size(); db = dv_q.size(); fb = fe_q.size();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (start_q.size() - sb != 0 || bus.busy !== 1'b0 || dv_q.size() - db != 0 || fe_q.size() - fb != 0) begin
            errors++;
            $display("FAIL midreset_stays_idle: starts=%0d busy=%b dv=%0d fe=%0d want 0",
                     start_q.size() - sb, bus.busy, dv_q.size() - db, fe_q.size() - fb);
        end
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_par_en_toggle;
        int sb, db, pb, lat;
        bit ok;
        sb = start_q.size(); db = dv_q.size(); pb = par_chk_cnt;
        configure(8, 1'b1, 1'b0, 1'b0, 1'b0);
        fork
            drive_frame(8, 1'b1, 8'h96);
            begin
                repeat (24) @(posedge clk);
                #1;
                bus.par_en = 1'b0;
            end
        join
        wait_idle(100, ok);
        lat = (dv_q.size() > db && start_q.size() > sb) ? dv_q[db] - start_q[sb] : -1;
        checks++;
        if (!ok || par_chk_cnt - pb != 1 || lat != frame_cycles(8, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL toggle_first: par=%0d lat=%0d want 1/%0d", par_chk_cnt - pb, lat,
                     frame_cycles(8, 1'b1, 1'b0));
        end
        sb = start_q.size(); db = dv_q.size(); pb = par_chk_cnt;
        drive_frame(8, 1'b0, 8'h69);
        wait_idle(100, ok);
        lat = (dv_q.size() > db && start_q.size() > sb) ? dv_q[db] - start_q[sb] : -1;
        checks++;
        if (!ok || par_chk_cnt - pb != 0 || lat != frame_cycles(8, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL toggle_second: par=%0d lat=%0d want 0/%0d", par_chk_cnt - pb, lat,
                     frame_cycles(8, 1'b0, 1'b0));
        end
        $display("test_par_en_toggle done");
    endtask

    task automatic test_bitcnt_overrun;
        int sb, db, fb, deb, lat;
        bit ok;
        sb = start_q.size(); db = dv_q.size(); fb = fe_q.size(); deb = deser_cnt;
        configure(8, 1'b0, 1'b0, 1'b0, 1'b0);
        skip_at = DW - 1;
        drive_frame(8, 1'b0, 8'hFF);
        wait_idle(100, ok);
        skip_at = -1;
        // Counter jumps from bit DW-1 past DW: START + DW data periods, then abort.
        lat = (fe_q.size() > fb && start_q.size() > sb) ? fe_q[fb] - start_q[sb] : -1;
        checks++;
        if (!ok || lat != 8 * (1 + DW) || dv_q.size() - db != 0 || fe_q.size() - fb != 1) begin
            errors++;
            $display("FAIL overrun: lat=%0d fe=%0d dv=%0d want %0d/1/0", lat, fe_q.size() - fb,
                     dv_q.size() - db, 8 * (1 + DW));
        end
        checks++;
        if (deser_cnt - deb != DW) begin
            errors++;
            $display("FAIL overrun_deser: got %0d want %0d", deser_cnt - deb, DW);
        end
        $display("test_bitcnt_overrun lat=%0d", lat);
    endtask

    task automatic test_random;
        int ps [3];
        ps = '{8, 16, 32};
        for (int f = 0; f < 12; f++) begin
            int p, sb, eb, db, fb, deb, pb, spb, lat, want_dv, want_fe;
            bit pen, glitch, perr, serr, ok;
            logic [7:0] data;
            p      = ps[$urandom_range(0, 2)];
            pen    = 1'($urandom_range(0, 1));
            glitch = ($urandom_range(0, 4) == 0);
            perr   = pen && ($urandom_range(0, 2) == 0);
            serr   = ($urandom_range(0, 3) == 0);
            data   = 8'($urandom);
            sb = start_q.size(); eb = end_q.size(); db = dv_q.size(); fb = fe_q.size();
            deb = deser_cnt; pb = par_chk_cnt; spb = stp_chk_cnt;
            configure(p, pen, glitch, perr, serr);
            if (glitch) begin
                bus.rx_in = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                bus.rx_in = 1'b1;
            end else begin
                drive_frame(p, pen, data);
            end
            wait_idle(40 * 12, ok);
            want_dv = (!glitch && !(perr || serr)) ? 1 : 0;
            want_fe = (!glitch &&  (perr || serr)) ? 1 : 0;
            if (end_q.size() > eb && start_q.size() > sb) lat = end_q[eb] - start_q[sb];
            else lat = -1;
            checks++;
            if (!ok || lat != frame_cycles(p, pen, glitch)) begin
                errors++;
                $display("FAIL rand%0d_busy_len: got %0d want %0d", f, lat, frame_cycles(p, pen, glitch));
            end
            checks++;
            if (dv_q.size() - db != want_dv || fe_q.size() - fb != want_fe) begin
                errors++;
                $display("FAIL rand%0d_result: dv=%0d fe=%0d want %0d/%0d", f, dv_q.size() - db,
                         fe_q.size() - fb, want_dv, want_fe);
            end
            checks++;
            if (deser_cnt - deb != (glitch ? 0 : DW) || par_chk_cnt - pb != ((!glitch && pen) ? 1 : 0) ||
                stp_chk_cnt - spb != (glitch ? 0 : 1)) begin
                errors++;
                $display("FAIL rand%0d_strobes: deser=%0d par=%0d stp=%0d", f, deser_cnt - deb,
                         par_chk_cnt - pb, stp_chk_cnt - spb);
            end
            $display("frame %0d p=%0d pen=%0d glitch=%0d perr=%0d serr=%0d data=%02h len=%0d",
                     f, p, pen, glitch, perr, serr, data, lat);
        end
        checks++;
        if (both_cnt != 0 || strobe_bad != 0) begin
            errors++;
            $display("FAIL global_invariants: both=%0d strobe_bad=%0d want 0/0", both_cnt, strobe_bad);
        end
    endtask

    initial begin
        bus.rx_in = 1'b1;
        configure(8, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        test_reset();
        test_clean_frame();
        test_parity_error();
        test_start_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_par_en_toggle();
        test_bitcnt_overrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
